// File: rtl/uart_port_if.sv
// CPU-side read/write handshake bundle for uart_port.
interface uart_port_if;
  logic       uartReadReq;
  logic       uartReadAck;
  logic [7:0] uartReadData;
  logic       uartWriteReq;
  logic [7:0] uartWriteData;
  logic       uartWriteReady;

  modport master (
    output uartReadReq, uartWriteReq, uartWriteData,
    input  uartReadAck, uartReadData, uartWriteReady
  );

  modport slave (
    input  uartReadReq, uartWriteReq, uartWriteData,
    output uartReadAck, uartReadData, uartWriteReady
  );
endinterface

// File: rtl/uart_port.sv
// 8N1 UART with a CPU read/write handshake and a small receive FIFO.
// TX and RX run independently from one clock; RX input is double-synchronized.
module uart_port #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned RX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  uart_port_if.slave  bus,
  input  logic        rxPin,
  output logic        txPin,
  output logic [4:0]  rxCount,
  output logic        rxOverrun,
  output logic        rxFrameErr
);

  localparam int unsigned     CW        = $clog2(CLKS_PER_BIT);
  localparam int unsigned     AW        = $clog2(RX_DEPTH);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [4:0]      DEPTH5    = 5'(RX_DEPTH);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [1:0] {X_IDLE, X_START, X_DATA, X_STOP} rx_state_e;
  typedef enum logic       {R_IDLE, R_WAIT_DROP}             rd_state_e;

  // ---------------- transmit ----------------
  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_q;
  logic          ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      case (tx_state_q)
        T_IDLE: begin
          tx_q     <= 1'b1;
          tx_cnt_q <= '0;
          if (ready_q && bus.uartWriteReq) begin
            tx_shift_q <= bus.uartWriteData;
            ready_q    <= 1'b0;
            tx_q       <= 1'b0;
            tx_state_q <= T_START;
          end else begin
            ready_q <= 1'b1;
          end
        end
        T_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= T_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        T_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= T_STOP;
            end else begin
              // Shift register keeps the next bit at [1] so txPin stays registered.
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        T_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            ready_q    <= 1'b1;
            tx_state_q <= T_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  // ---------------- receive ----------------
  logic          sync1_q, sync2_q, rx_prev_q;
  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          frame_err_q;
  logic          rx_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rxPin;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // High for the one cycle in which the stop bit centre is sampled.
  assign rx_done = (rx_state_q == X_STOP) && (rx_cnt_q == BIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q  <= X_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      case (rx_state_q)
        X_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !sync2_q) rx_state_q <= X_START;
        end
        X_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= sync2_q ? X_IDLE : X_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        X_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {sync2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= X_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        X_STOP: begin
          if (rx_done) begin
            rx_cnt_q   <= '0;
            rx_state_q <= X_IDLE;
            if (!sync2_q) frame_err_q <= 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= X_IDLE;
      endcase
    end
  end

  // ---------------- FIFO and read handshake ----------------
  logic [7:0]    mem_q [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    count_q;
  logic          overrun_q;
  rd_state_e     rd_state_q;
  logic          ack_q;
  logic [7:0]    rdata_q;
  logic          pop, push, drop, full;

  assign full = (count_q == DEPTH5);
  assign pop  = (rd_state_q == R_IDLE) && bus.uartReadReq && (count_q != '0);
  // A simultaneous pop frees the slot the incoming byte needs.
  assign push = rx_done && sync2_q && (!full || pop);
  assign drop = rx_done && sync2_q && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      rd_state_q <= R_IDLE;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) overrun_q <= 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
      case (rd_state_q)
        R_IDLE: begin
          if (pop) begin
            ack_q      <= 1'b1;
            rdata_q    <= mem_q[rd_ptr_q];
            rd_state_q <= R_WAIT_DROP;
          end
        end
        R_WAIT_DROP: begin
          if (!bus.uartReadReq) rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign bus.uartReadAck    = ack_q;
  assign bus.uartReadData   = rdata_q;
  assign bus.uartWriteReady = ready_q;
  assign txPin              = tx_q;
  assign rxCount            = count_q;
  assign rxOverrun          = overrun_q;
  assign rxFrameErr         = frame_err_q;

endmodule
